// File: rtl/nes_pad_responder.sv
// Device-side NES pad emulator: oversamples the console latch/clock in the clk domain
// and serves 8 button bits (then fill bits) on the data wire.
module nes_pad_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int ACTIVE_LOW     = 1,
    parameter int FILL_PRESSED   = 1,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] btn,
    input  logic       nes_latch,
    input  logic       nes_clk,
    output logic       nes_data,
    output logic [3:0] bit_idx,
    output logic       frame_done,
    output logic       link_lost
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam logic RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic FILL_BIT = (FILL_PRESSED != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LATCHED = 2'd1;
    localparam logic [1:0] S_SHIFT   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    function automatic logic wire_level(input logic pressed);
        return (ACTIVE_LOW != 0) ? ~pressed : pressed;
    endfunction

    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic                   latch_prev;
    logic                   clk_prev;
    logic                   latch_s;
    logic                   latch_rise;
    logic                   clk_rise;

    logic [1:0]      state;
    logic [1:0]      state_n;
    logic [7:0]      shreg;
    logic [7:0]      shreg_n;
    logic [3:0]      idx_n;
    logic            done_n;
    logic            data_n;
    logic [WD_W-1:0] watchdog;
    logic [WD_W-1:0] wd_n;

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_prev;
    assign clk_rise   = clk_sync[SYNC_STAGES-1] & ~clk_prev;

    // Synchronizers and edge detectors run regardless of en, so a latch that is
    // already high when en returns does not look like a fresh rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch_sync <= '0;
            clk_sync   <= '0;
            latch_prev <= 1'b0;
            clk_prev   <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], nes_latch};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], nes_clk};
            latch_prev <= latch_s;
            clk_prev   <= clk_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = bit_idx;
        done_n  = 1'b0;
        wd_n    = watchdog;
        if (!en) begin
            state_n = S_IDLE;
            idx_n   = 4'd0;
            wd_n    = '0;
        end else begin
            if (latch_rise)
                wd_n = '0;
            else if (watchdog != WD_MAX)
                wd_n = watchdog + 1'b1;

            // Latch rise restarts the frame from any state and swallows a coincident clk edge.
            if (latch_rise) begin
                state_n = S_LATCHED;
                shreg_n = btn;
                idx_n   = 4'd0;
            end else begin
                case (state)
                    S_LATCHED: begin
                        idx_n = 4'd0;
                        if (latch_s)
                            shreg_n = btn;
                        else
                            state_n = S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (clk_rise && !latch_s) begin
                            shreg_n = {FILL_BIT, shreg[7:1]};
                            idx_n   = bit_idx + 4'd1;
                            if (bit_idx == 4'd7) begin
                                state_n = S_DONE;
                                done_n  = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        case (state_n)
            S_IDLE:  data_n = RELEASED;
            S_DONE:  data_n = wire_level(FILL_BIT);
            default: data_n = wire_level(shreg_n[0]);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            shreg      <= 8'h00;
            bit_idx    <= 4'd0;
            frame_done <= 1'b0;
            watchdog   <= '0;
            link_lost  <= 1'b0;
            nes_data   <= RELEASED;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_idx    <= idx_n;
            frame_done <= done_n;
            watchdog   <= wd_n;
            link_lost  <= (wd_n == WD_MAX);
            nes_data   <= data_n;
        end
    end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed + randomized bench for nes_pad_responder with a frame-level reference model
// (expected wire bit = button k after k shifts, fill afterwards).
module tb_nes_pad_responder;

    localparam int   SYNC       = 2;
    localparam int   ACTIVE_LOW = 1;
    localparam logic FILL       = 1'b1;
    localparam int   TMO        = 100;
    localparam int   SETTLE     = SYNC + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [7:0] btn = 8'h00;
    logic       nes_latch = 1'b0;
    logic       nes_clk = 1'b0;
    logic       nes_data;
    logic [3:0] bit_idx;
    logic       frame_done;
    logic       link_lost;

    int vectors = 0;
    int miscompares = 0;
    int fd_count = 0;

    logic [7:0] frame_btn = 8'h00;
    int         shifts = 0;

    nes_pad_responder #(
        .SYNC_STAGES(SYNC),
        .ACTIVE_LOW(ACTIVE_LOW),
        .FILL_PRESSED(1),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .btn(btn),
        .nes_latch(nes_latch),
        .nes_clk(nes_clk),
        .nes_data(nes_data),
        .bit_idx(bit_idx),
        .frame_done(frame_done),
        .link_lost(link_lost)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    function automatic logic wire_of(input logic pressed);
        return (ACTIVE_LOW != 0) ? ~pressed : pressed;
    endfunction

    function automatic logic exp_wire(input int k);
        logic pressed;
        if (k >= 8) pressed = FILL;
        else        pressed = frame_btn[k[2:0]];
        return wire_of(pressed);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input logic [7:0] b, input int width, input bit clk_noise);
        btn = b;
        frame_btn = b;
        shifts = 0;
        nes_latch = 1'b1;
        cyc(SETTLE);
        check("latch_data", nes_data, wire_of(b[0]));
        check("latch_idx", bit_idx, 0);
        check("latch_link", link_lost, 0);
        if (clk_noise) begin
            nes_clk = 1'b1;
            cyc(2);
            nes_clk = 1'b0;
            cyc(SETTLE);
            check("noise_idx", bit_idx, 0);
            check("noise_data", nes_data, wire_of(b[0]));
        end
        cyc(width);
        nes_latch = 1'b0;
        cyc(SETTLE);
        check("fall_idx", bit_idx, 0);
        check("fall_data", nes_data, wire_of(b[0]));
        btn = 8'($urandom);
    endtask

    task automatic shift_pulse(input int hi, input int lo);
        nes_clk = 1'b1;
        cyc(hi);
        nes_clk = 1'b0;
        cyc(lo);
        shifts++;
        check("shift_data", nes_data, exp_wire(shifts));
        check("shift_idx", bit_idx, (shifts > 8) ? 8 : shifts);
    endtask

    task automatic rand_pulses(input int n);
        for (int i = 0; i < n; i++) shift_pulse($urandom_range(6, 2), $urandom_range(6, 2));
    endtask

    initial begin
        int fd0;
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fd0;
        // Reset values
        en = 1'b1;
        cyc(3);
        check("rst_data", nes_data, 1);
        check("rst_idx", bit_idx, 0);
        check("rst_done", frame_done, 0);
        check("rst_link", link_lost, 0);

        // Watchdog timeout and recovery
        reset = 1'b1;
        cyc(TMO - 1);
        check("wd_before", link_lost, 0);
        cyc(1);
        check("wd_at", link_lost, 1);
        cyc(20);
        check("wd_sat", link_lost, 1);
        nes_latch = 1'b1;
        cyc(SYNC);
        check("wd_hold", link_lost, 1);
        cyc(1);
        check("wd_clear", link_lost, 0);
        cyc(4);
        nes_latch = 1'b0;
        cyc(SETTLE);

        // Spec timing frame, btn=01, with pin-to-wire latency
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(2);
        fd0 = fd_count;
        btn = 8'h01;
        frame_btn = 8'h01;
        shifts = 0;
        nes_latch = 1'b1;
        cyc(SYNC);
        check("lat_before", nes_data, 1);
        cyc(1);
        check("lat_after", nes_data, 0);
        cyc(600 - SYNC - 1);
        nes_latch = 1'b0;
        cyc(SETTLE);
        check("t1_first", nes_data, 0);
        for (int i = 0; i < 8; i++) shift_pulse(150, 150);
        check("t1_done", fd_count - fd0, 1);
        check("t1_idx", bit_idx, 8);

        // A5 with three extra clocks reading fill
        fd0 = fd_count;
        start_frame(8'hA5, 6, 1'b0);
        rand_pulses(11);
        check("t2_done", fd_count - fd0, 1);

        // Abort mid-shift by a new latch
        fd0 = fd_count;
        start_frame(8'hFF, 4, 1'b0);
        rand_pulses(3);
        start_frame(8'h00, 4, 1'b0);
        check("t3_abort", fd_count - fd0, 0);
        rand_pulses(8);
        check("t3_done", fd_count - fd0, 1);

        // Latch and clk rising together
        btn = 8'h5B;
        frame_btn = 8'h5B;
        shifts = 0;
        nes_latch = 1'b1;
        nes_clk = 1'b1;
        cyc(SETTLE);
        check("t4_idx", bit_idx, 0);
        check("t4_data", nes_data, wire_of(1'b1));
        nes_clk = 1'b0;
        cyc(3);
        nes_latch = 1'b0;
        cyc(SETTLE);
        check("t4_first", nes_data, wire_of(1'b1));
        rand_pulses(8);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            int n;
            n = $urandom_range(11, 0);
            fd0 = fd_count;
            start_frame(8'($urandom), $urandom_range(20, 1), 1'($urandom));
            rand_pulses(n);
            check("rnd_done", fd_count - fd0, (n >= 8) ? 1 : 0);
        end

        // Async reset mid-shift
        start_frame(8'h3C, 3, 1'b0);
        rand_pulses(4);
        check("t6_idx4", bit_idx, 4);
        #3 reset = 1'b0;
        #1;
        check("t6_rdata", nes_data, 1);
        check("t6_ridx", bit_idx, 0);
        check("t6_rdone", frame_done, 0);
        check("t6_rlink", link_lost, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(3);
        check("t6_idle", nes_data, 1);

        // en=0 mid-frame, then en returning with latch already high
        start_frame(8'h01, 3, 1'b0);
        rand_pulses(4);
        en = 1'b0;
        cyc(1);
        check("en_idx", bit_idx, 0);
        check("en_data", nes_data, 1);
        check("en_link", link_lost, 0);
        check("en_done", frame_done, 0);
        btn = 8'h01;
        nes_latch = 1'b1;
        cyc(SETTLE);
        en = 1'b1;
        cyc(SETTLE);
        check("en_nolatch", nes_data, 1);
        nes_clk = 1'b1;
        cyc(2);
        nes_clk = 1'b0;
        cyc(SETTLE);
        check("en_noshift", bit_idx, 0);
        nes_latch = 1'b0;
        cyc(SETTLE);
        fd0 = fd_count;
        start_frame(8'h01, 4, 1'b0);
        rand_pulses(8);
        check("en_frame", fd_count - fd0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
